// File: rtl/hazard_forward_unit.sv
`default_nettype none
// hazard_forward_unit: scoreboard-based operand forwarding, load-use stall and
// branch flush control with saturating stall/flush performance counters.
module hazard_forward_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int DEPTH        = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_we,
  input  logic                  id_load,
  input  logic                  br_taken,
  output logic [DEPTH-1:0]      fwd_a_sel,
  output logic [DEPTH-1:0]      fwd_b_sel,
  output logic                  stall,
  output logic                  flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [FCNT_W-1:0] FCNT_RELOAD =
    FCNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t                  state;
  logic [FCNT_W-1:0]       fcnt;
  logic [DEPTH-1:0]        sb_v;
  logic [DEPTH-1:0]        sb_ld;
  logic [REG_ADDR_W-1:0]   sb_rd [DEPTH];

  logic [DEPTH-1:0]        win_a, win_b;
  logic                    lu_a, lu_b, load_use;

  // Descending scan so the youngest (lowest-index) match overwrites older ones.
  always_comb begin
    win_a = '0;
    win_b = '0;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sb_v[i] && (sb_rd[i] == id_rs1) && (id_rs1 != '0) && id_use_rs1 && id_valid) begin
        win_a    = '0;
        win_a[i] = 1'b1;
        lu_a     = sb_ld[i] && (i < LOAD_LAT);
      end
      if (sb_v[i] && (sb_rd[i] == id_rs2) && (id_rs2 != '0) && id_use_rs2 && id_valid) begin
        win_b    = '0;
        win_b[i] = 1'b1;
        lu_b     = sb_ld[i] && (i < LOAD_LAT);
      end
    end
  end

  // flush is gated by rst_n so an in-reset br_taken cannot leak out.
  assign load_use  = lu_a | lu_b;
  assign flush     = rst_n & (br_taken | (state == ST_FLUSH));
  assign stall     = load_use & ~flush;
  assign fwd_a_sel = load_use ? '0 : win_a;
  assign fwd_b_sel = load_use ? '0 : win_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v  <= '0;
      sb_ld <= '0;
      for (int i = 0; i < DEPTH; i++) sb_rd[i] <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        sb_v[i]  <= sb_v[i-1];
        sb_ld[i] <= sb_ld[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
      sb_v[0]  <= id_valid & id_we & (id_rd != '0) & ~stall & ~flush;
      sb_ld[0] <= id_load;
      sb_rd[0] <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      fcnt  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (br_taken && (FLUSH_CYCLES > 1)) begin
            state <= ST_FLUSH;
            fcnt  <= FCNT_RELOAD;
          end
        end
        ST_FLUSH: begin
          if (br_taken) begin
            fcnt <= FCNT_RELOAD;
          end else if (fcnt == '0) begin
            state <= ST_RUN;
          end else begin
            fcnt <= fcnt - 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// tb_hazard_forward_unit: directed vectors with hand-computed expectations.
module tb_hazard_forward_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_we, id_load, br_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] fwd_a_sel, fwd_b_sel;
  logic       stall, flush;
  logic [3:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int errs    = 0;

  hazard_forward_unit #(
    .REG_ADDR_W(5), .DEPTH(3), .LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_load(id_load), .br_taken(br_taken), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply decode-stage inputs shortly after a rising edge and let them settle.
  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic br);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_we = we; id_load = ld; br_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 5'd7, 5'd7, 1, 1, 5'd7, 1, 1, 1);
    chk("rst_flush", flush, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // RAW back-to-back: add x5 ; add x6,x5,x1
    drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    chk("raw_pre_a", fwd_a_sel, 3'b000);
    tick();
    drive(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0);
    chk("raw_fwd_a", fwd_a_sel, 3'b001);
    chk("raw_fwd_b", fwd_b_sel, 3'b000);
    chk("raw_stall", stall, 0);
    tick();

    // Shadowing: x5 at entries 1 and 2, x9 at entry 0
    drive(1, 0, 0, 0, 0, 5'd5, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 5'd5, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 5'd9, 1, 0, 0); tick();
    drive(1, 5'd5, 5'd9, 1, 1, 5'd0, 0, 0, 0);
    chk("shadow_fwd_a", fwd_a_sel, 3'b010);
    chk("shadow_fwd_b", fwd_b_sel, 3'b001);
    tick();

    // Load-use: lw x7 ; add x8,x7,x7
    drive(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 0);
    chk("lw_fwd_a", fwd_a_sel, 3'b000);
    tick();
    drive(1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 0);
    chk("lu_stall", stall, 1);
    chk("lu_fwd_a", fwd_a_sel, 3'b000);
    chk("lu_fwd_b", fwd_b_sel, 3'b000);
    tick();
    chk("lu2_stall", stall, 0);
    chk("lu2_fwd_a", fwd_a_sel, 3'b010);
    chk("lu2_fwd_b", fwd_b_sel, 3'b010);
    chk("lu2_stall_cnt", stall_cnt, 1);
    tick();

    // x0 writer and unused rs2 that would match x8
    drive(1, 0, 0, 0, 0, 5'd0, 1, 0, 0); tick();
    drive(1, 5'd0, 5'd8, 1, 0, 5'd0, 0, 0, 0);
    chk("x0_fwd_a", fwd_a_sel, 3'b000);
    chk("nouse_fwd_b", fwd_b_sel, 3'b000);
    tick();

    // Branch flush with a concurrent load-use that must be suppressed
    drive(1, 0, 0, 0, 0, 5'd7, 1, 1, 0); tick();
    drive(1, 5'd7, 5'd0, 1, 0, 5'd3, 1, 0, 1);
    chk("br_flush_c1", flush, 1);
    chk("br_stall_supp", stall, 0);
    tick();
    drive(1, 5'd7, 5'd0, 1, 0, 5'd3, 1, 0, 0);
    chk("br_flush_c2", flush, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_flush_c3", flush, 0);
    chk("br_flush_cnt", flush_cnt, 2);
    chk("br_stall_cnt", stall_cnt, 1);
    tick();

    // Second br_taken on flush cycle 2 extends to cycle 3
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ext_c1", flush, 1);
    tick();
    chk("ext_c2", flush, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ext_c3", flush, 1);
    tick();
    chk("ext_c4", flush, 0);
    chk("ext_flush_cnt", flush_cnt, 5);

    // Saturation: self-dependent load stalls every other cycle
    drive(1, 5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 0);
    for (int i = 0; i < 40; i++) tick();
    chk("sat_stall_cnt", stall_cnt, 15);

    // Async reset in the middle of a flush
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 5'd7, 5'd7, 1, 1, 5'd7, 1, 1, 0);
    chk("mid_flush", flush, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_flush", flush, 0);
    chk("arst_stall", stall, 0);
    chk("arst_fwd_a", fwd_a_sel, 3'b000);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_flush_cnt", flush_cnt, 0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("post_rst_flush", flush, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
`default_nettype wire
